// File: rtl/galois_pkg.sv
// Shared defaults and FSM state type for the sequential GF(p) multiplier.
// Optional feature macro: GALOIS_MULT_EARLY_EXIT_EN (see galois_mult_seq).
package galois_pkg;

    localparam int unsigned N_BITS_DEFAULT = 254;

    // BN254 scalar field prime.
    localparam logic [253:0] PRIME_MODULUS_DEFAULT =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/galois_add.sv
// Modular adder: sum = (a + b) mod p for a, b in [0, p-1].
// Uses an N_BITS+1-bit raw sum and a single conditional subtraction of p.
module galois_add
    import galois_pkg::*;
#(
    parameter int unsigned           N_BITS        = N_BITS_DEFAULT,
    parameter logic [N_BITS-1:0]     PRIME_MODULUS = PRIME_MODULUS_DEFAULT
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] sum
);

    logic [N_BITS:0]   sum_full;
    logic [N_BITS-1:0] sum_reduced;
    logic              ge_p;

    always_comb begin
        sum_full    = {1'b0, a} + {1'b0, b};
        ge_p        = (sum_full >= {1'b0, PRIME_MODULUS});
        // True difference is below p < 2^N_BITS, so the wrapped N_BITS result is exact.
        sum_reduced = sum_full[N_BITS-1:0] - PRIME_MODULUS;
        sum         = ge_p ? sum_reduced : sum_full[N_BITS-1:0];
    end

endmodule

// File: rtl/galois_mult_seq.sv
// Sequential GF(p) multiplier, LSB-first double-and-add, one multiplier bit per cycle.
// Define GALOIS_MULT_EARLY_EXIT_EN to finish once the remaining multiplier bits are all zero.
module galois_mult_seq
    import galois_pkg::*;
#(
    parameter int unsigned       N_BITS        = N_BITS_DEFAULT,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = PRIME_MODULUS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] num1,
    input  logic [N_BITS-1:0] num2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] product
);

    localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    state_e            state_q, state_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic [N_BITS-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_BITS-1:0] acc_plus_a;
    logic [N_BITS-1:0] a_doubled;

    galois_add #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_add_acc (
        .a   (acc_q),
        .b   (a_q),
        .sum (acc_plus_a)
    );

    galois_add #(
        .N_BITS        (N_BITS),
        .PRIME_MODULUS (PRIME_MODULUS)
    ) u_add_dbl (
        .a   (a_q),
        .b   (a_q),
        .sum (a_doubled)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        product   = '0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = num1;
                    b_d     = num2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
`ifdef GALOIS_MULT_EARLY_EXIT_EN
                    if (num2 == '0) begin
                        state_d = StDone;
                    end
`endif
                end
            end

            StBusy: begin
                if (b_q[0]) begin
                    acc_d = acc_plus_a;
                end
                a_d   = a_doubled;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
`ifdef GALOIS_MULT_EARLY_EXIT_EN
                if ((b_q >> 1) == '0) begin
                    state_d = StDone;
                end
`else
                // Fixed latency: the bit index alone decides completion.
                if (cnt_q == CNT_W'(N_BITS - 1)) begin
                    state_d = StDone;
                end
`endif
            end

            StDone: begin
                out_valid = 1'b1;
                product   = acc_q;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_galois_mult_seq.sv
// Self-checking bench for galois_mult_seq against a wide-integer (a*b) mod p model.
// Honours GALOIS_MULT_EARLY_EXIT_EN for the expected latency.
module tb_galois_mult_seq;
    import galois_pkg::*;

    localparam int unsigned N         = N_BITS_DEFAULT;
    localparam logic [N-1:0] P        = PRIME_MODULUS_DEFAULT;
    localparam int           LAT_LIMIT = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] num1;
    logic [N-1:0] num2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] product;

    int errors = 0;
    int checks = 0;

    galois_mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num1      (num1),
        .num2      (num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] model_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] full;
        logic [2*N-1:0] rem;
        full = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        rem  = full % {{N{1'b0}}, P};
        return rem[N-1:0];
    endfunction

    function automatic int exp_latency(input logic [N-1:0] y);
`ifdef GALOIS_MULT_EARLY_EXIT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < int'(N); i++) begin
            if (y[i]) msb = i;
        end
        // Zero multiplier: result is visible right after the accepting edge.
        return (msb < 0) ? 0 : msb + 1;
`else
        return (y == y) ? int'(N) : 0;
`endif
    endfunction

    function automatic logic [N-1:0] rand_elem();
        logic [255:0] r;
        logic [N-1:0] v;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        v = r[N-1:0];
        return v % P;
    endfunction

    // One transaction: accept, wait for result, stall `stall` cycles in DONE, then handshake.
    task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                          input int stall, input bit chk_lat);
        int           lat;
        logic [N-1:0] held;
        logic [N-1:0] exp;
        exp = model_mul(x, y);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, (N+1)'(in_ready), (N+1)'(1));
        num1     = x;
        num2     = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num1     = '0;
        num2     = '0;
        lat      = 0;
        while (!out_valid && lat < LAT_LIMIT) begin
            if (lat == 2) begin
                check({tag, ".busy_product_zero"}, (N+1)'(product), '0);
                check({tag, ".busy_in_ready"}, (N+1)'(in_ready), '0);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            check({tag, ".timeout"}, (N+1)'(out_valid), (N+1)'(1));
            return;
        end
        if (chk_lat) check({tag, ".latency"}, (N+1)'(lat), (N+1)'(exp_latency(y)));
        check({tag, ".product"}, (N+1)'(product), (N+1)'(exp));
        held = product;
        for (int s = 0; s < stall; s++) begin
            in_valid = s[0];
            num1     = rand_elem();
            num2     = rand_elem();
            @(posedge clk);
            #1;
            check({tag, ".stall_valid"}, (N+1)'(out_valid), (N+1)'(1));
            check({tag, ".stall_stable"}, (N+1)'(product), (N+1)'(held));
            check({tag, ".stall_in_ready"}, (N+1)'(in_ready), '0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".post_valid"}, (N+1)'(out_valid), '0);
        check({tag, ".post_product"}, (N+1)'(product), '0);
    endtask

    initial begin
        logic [N-1:0] x;
        logic [N-1:0] y;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num1      = '0;
        num2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", (N+1)'(in_ready), (N+1)'(1));
        check("reset.out_valid", (N+1)'(out_valid), '0);
        check("reset.product", (N+1)'(product), '0);
        rst = 1'b0;

        run_op("small_3x5", N'(3), N'(5), 0, 1'b1);
        check("model_3x5", (N+1)'(model_mul(N'(3), N'(5))), (N+1)'(15));
        run_op("pm1_sq", P - 1'b1, P - 1'b1, 0, 1'b1);
        check("model_pm1_sq", (N+1)'(model_mul(P - 1'b1, P - 1'b1)), (N+1)'(1));
        run_op("pm1_x2", P - 1'b1, N'(2), 1, 1'b1);
        check("model_pm1_x2", (N+1)'(model_mul(P - 1'b1, N'(2))), (N+1)'(P - 2'd2));
        run_op("zero_mult", N'(16'h1234), '0, 0, 1'b1);
        run_op("stall10", N'(16'hbeef), N'(32'h1234_5678), 10, 1'b1);

        // Reset 100 cycles into BUSY abandons the operation.
        @(negedge clk);
        num1     = N'(1234);
        num2     = P - 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("rst_busy.pre_valid", (N+1)'(out_valid), '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy.out_valid", (N+1)'(out_valid), '0);
        check("rst_busy.in_ready", (N+1)'(in_ready), (N+1)'(1));
        check("rst_busy.product", (N+1)'(product), '0);
        repeat (300) @(posedge clk);
        #1;
        check("rst_busy.no_late_result", (N+1)'(out_valid), '0);
        run_op("after_rst_7x6", N'(7), N'(6), 0, 1'b1);
        check("model_7x6", (N+1)'(model_mul(N'(7), N'(6))), (N+1)'(42));

        for (int i = 0; i < 40; i++) begin
            x = rand_elem();
            y = rand_elem();
            run_op($sformatf("rand%0d", i), x, y, $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
